// File: rtl/ccff_chain_loader_if.sv
// Bitstream-side bundle for ccff_chain_loader: word handshake, chain head/tail and status.
// master = bitstream source / chain model side, slave = loader.
interface ccff_chain_loader_if #(
    parameter int unsigned WORD_W = 8
);
    logic              START;
    logic [WORD_W-1:0] WDATA;
    logic              WVALID;
    logic              WREADY;
    logic              HEAD;
    logic              SHIFT_EN;
    logic              TAIL;
    logic              BUSY;
    logic              DONE;
    logic [WORD_W-1:0] RDATA;
    logic              RVALID;

    modport master (
        output START, WDATA, WVALID, TAIL,
        input  WREADY, HEAD, SHIFT_EN, BUSY, DONE, RDATA, RVALID
    );

    modport slave (
        input  START, WDATA, WVALID, TAIL,
        output WREADY, HEAD, SHIFT_EN, BUSY, DONE, RDATA, RVALID
    );
endinterface

// File: rtl/ccff_chain_loader.sv
// Parallel-to-serial loader shifting CHAIN_LEN bits MSB-first into a CCFF chain head.
// Define CCFF_READBACK_EN to build the tail capture path (RDATA/RVALID).
module ccff_chain_loader #(
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              CK,
    input  logic              RSTN,
    ccff_chain_loader_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned KW    = $clog2(WORD_W + 1);
    localparam int unsigned MW    = (CNT_W > KW) ? CNT_W : KW;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [KW-1:0]     kcnt_q, kcnt_d;
    logic              wready_q, wready_d;
    logic              head_q, head_d;
    logic              shift_en_q, shift_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [MW-1:0]     remain;
    logic [MW-1:0]     k_sel;
    logic              accept;
    logic              last_shift;

    // Bits still owed to the chain bound the length of the next word's shift burst.
    always_comb begin
        remain     = MW'(CHAIN_LEN) - MW'(cnt_q);
        k_sel      = (remain < MW'(WORD_W)) ? remain : MW'(WORD_W);
        accept     = (state_q == S_LOAD) && bus.WVALID && wready_q;
        last_shift = (kcnt_q == KW'(1));
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        kcnt_d  = kcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    sr_d    = bus.WDATA;
                    kcnt_d  = KW'(k_sel);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sr_d   = sr_q << 1;
                cnt_d  = cnt_q + 1'b1;
                kcnt_d = kcnt_q - 1'b1;
                if (last_shift) begin
                    state_d = (cnt_q == CNT_W'(CHAIN_LEN - 1)) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so every port comes straight off a flop.
        wready_d   = (state_d == S_LOAD);
        shift_en_d = (state_d == S_SHIFT);
        head_d     = (state_d == S_SHIFT) && sr_d[WORD_W-1];
        busy_d     = (state_d == S_LOAD) || (state_d == S_SHIFT);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= S_IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            kcnt_q     <= '0;
            wready_q   <= 1'b0;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            kcnt_q     <= kcnt_d;
            wready_q   <= wready_d;
            head_q     <= head_d;
            shift_en_q <= shift_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.WREADY   = wready_q;
    assign bus.HEAD     = head_q;
    assign bus.SHIFT_EN = shift_en_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;

`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] cap_q, cap_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    // Capture is cleared per word so a partial last word lands right-justified.
    always_comb begin
        cap_d    = cap_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (accept) begin
            cap_d = '0;
        end
        if (state_q == S_SHIFT) begin
            cap_d = (cap_q << 1) | WORD_W'(bus.TAIL);
            if (last_shift) begin
                rdata_d  = cap_d;
                rvalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            cap_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            cap_q    <= cap_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.RDATA  = rdata_q;
    assign bus.RVALID = rvalid_q;
`else
    logic unused_tail;
    assign unused_tail = bus.TAIL;
    assign bus.RDATA   = '0;
    assign bus.RVALID  = 1'b0;
`endif
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized bench for ccff_chain_loader: 20-bit chain model, bit-stream and timing reference.
// Also exercises a CHAIN_LEN=1 instance and readback when CCFF_READBACK_EN is defined.
module tb_ccff_chain_loader;
    localparam int unsigned CL = 20;
    localparam int unsigned WW = 8;
`ifdef CCFF_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic CK   = 1'b0;
    logic RSTN = 1'b0;
    always #5 CK = ~CK;

    ccff_chain_loader_if #(.WORD_W(WW)) bus  ();
    ccff_chain_loader_if #(.WORD_W(WW)) bus1 ();

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut  (.CK(CK), .RSTN(RSTN), .bus(bus));
    ccff_chain_loader #(.CHAIN_LEN(1),  .WORD_W(WW)) dut1 (.CK(CK), .RSTN(RSTN), .bus(bus1));

    // Chain of CCFF cells: captures HEAD where SHIFT_EN is high, TAIL is the far cell.
    logic [CL-1:0] chain = 20'h5A0F3;
    always @(posedge CK) if (bus.SHIFT_EN) chain <= {chain[CL-2:0], bus.HEAD};
    assign bus.TAIL  = chain[CL-1];
    assign bus1.TAIL = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_gap(input int ncyc);
        int bad;
        bad = 0;
        repeat (ncyc) begin
            @(negedge CK);
            if (bus.WREADY || bus.BUSY || bus.SHIFT_EN || bus.DONE) bad++;
            bus.WVALID = 1'($urandom);
            bus.WDATA  = 8'($urandom);
        end
        bus.WVALID = 1'b0;
        check("idle_quiet", bad, 0);
    endtask

    // One complete 20-bit load; st* are source stall cycles seen in LOAD before each word.
    task automatic do_load(input logic [7:0] w0, w1, w2, input int st0, st1, st2, input bit noise);
        logic [7:0]    words [3];
        int            stall [3];
        logic [23:0]   stream;
        logic [CL-1:0] exp_chain, prev, got_head;
        logic [7:0]    exp_rd [3];
        int            exp_rv [3];
        logic [7:0]    last_rd;
        int            wi, left, n, exp_done, shifts, busy_n, overlap, rv_n, rv_bad, rd_bad;
        bit            got_done;

        words[0] = w0; words[1] = w1; words[2] = w2;
        stall[0] = st0; stall[1] = st1; stall[2] = st2;
        stream    = {w0, w1, w2};
        exp_chain = stream[23:4];
        prev      = chain;
        exp_rd[0] = prev[19:12];
        exp_rd[1] = prev[11:4];
        exp_rd[2] = {4'h0, prev[3:0]};
        exp_rv[0] = 1 + st0 + 9;
        exp_rv[1] = exp_rv[0] + st1 + 9;
        exp_done  = exp_rv[1] + st2 + 5;
        exp_rv[2] = exp_done;

        wi = 0; left = st0; n = 0; shifts = 0; busy_n = 0; overlap = 0;
        rv_n = 0; rv_bad = 0; rd_bad = 0; got_done = 1'b0; got_head = '0;
        last_rd = bus.RDATA;
        bus.START  = 1'b1;
        bus.WVALID = 1'b0;

        while (n < exp_done + 20 && !got_done) begin
            @(negedge CK);
            n++;
            if (bus.SHIFT_EN) begin
                shifts++;
                got_head = {got_head[CL-2:0], bus.HEAD};
            end
            if (bus.BUSY) busy_n++;
            if (bus.WREADY && bus.SHIFT_EN) overlap++;
            if (bus.RVALID) begin
                if (rv_n >= 3 || bus.RDATA !== exp_rd[rv_n] || n != exp_rv[rv_n]) rv_bad++;
                rv_n++;
            end
            if (RB ? (!bus.RVALID && bus.RDATA !== last_rd) : (bus.RVALID || bus.RDATA !== '0)) rd_bad++;
            last_rd = bus.RDATA;

            if (bus.DONE) begin
                got_done = 1'b1;
                check("done_cycle", n, exp_done);
                check("busy_at_done", bus.BUSY, 0);
            end else begin
                bus.START = noise && bus.BUSY && ($urandom_range(0, 7) == 0);
                if (bus.WREADY) begin
                    if (left > 0) begin
                        bus.WVALID = 1'b0;
                        bus.WDATA  = 8'($urandom);
                        left--;
                    end else begin
                        bus.WVALID = 1'b1;
                        bus.WDATA  = (wi < 3) ? words[wi] : 8'($urandom);
                        wi++;
                        left = (wi < 3) ? stall[wi] : 0;
                    end
                end else begin
                    bus.WVALID = noise ? 1'($urandom) : 1'b0;
                    bus.WDATA  = 8'($urandom);
                end
            end
        end
        bus.START  = 1'b0;
        bus.WVALID = 1'b0;

        check("done_seen", got_done, 1);
        check("shift_count", shifts, CL);
        check("head_stream", got_head, exp_chain);
        check("chain_contents", chain, exp_chain);
        check("busy_cycles", busy_n, exp_done - 1);
        check("wready_shift_overlap", overlap, 0);
        check("words_taken", wi, 3);
        check("rv_count", rv_n, RB ? 3 : 0);
        check("rv_data_timing", rv_bad, 0);
        check("rdata_stable", rd_bad, 0);
    endtask

    task automatic reset_mid();
        int n, sh;
        bit hit;
        n = 0; sh = 0; hit = 1'b0;
        bus.START = 1'b1;
        while (n < 40 && !hit) begin
            @(negedge CK);
            n++;
            bus.START = 1'b0;
            if (bus.SHIFT_EN) begin
                sh++;
                if (sh == 3) hit = 1'b1;
            end
            bus.WVALID = bus.WREADY;
            bus.WDATA  = 8'($urandom);
        end
        check("rst_reached_shift3", hit, 1);
        #2 RSTN = 1'b0;
        #1;
        check("rst_async_outs", {bus.WREADY, bus.HEAD, bus.SHIFT_EN, bus.BUSY, bus.DONE, bus.RVALID}, 0);
        check("rst_async_rdata", bus.RDATA, 0);
        @(negedge CK);
        RSTN = 1'b1;
        bus.WVALID = 1'b0;
        @(negedge CK);
        check("rst_idle_after", {bus.BUSY, bus.WREADY, bus.SHIFT_EN}, 0);
    endtask

    task automatic len1_load();
        int n, sh, dn;
        logic hd;
        n = 0; sh = 0; dn = 0; hd = 1'b0;
        bus1.WDATA  = 8'h80;
        bus1.WVALID = 1'b1;
        bus1.START  = 1'b1;
        repeat (8) begin
            @(negedge CK);
            n++;
            bus1.START = 1'b0;
            if (bus1.SHIFT_EN) begin
                sh++;
                hd = bus1.HEAD;
            end
            if (bus1.DONE && dn == 0) dn = n;
        end
        bus1.WVALID = 1'b0;
        check("len1_shifts", sh, 1);
        check("len1_head", hd, 1);
        check("len1_done_cycle", dn, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.START = 1'b0;  bus.WVALID = 1'b0;  bus.WDATA = '0;
        bus1.START = 1'b0; bus1.WVALID = 1'b0; bus1.WDATA = '0;
        repeat (3) @(negedge CK);
        check("rst_wready", bus.WREADY, 0);
        check("rst_head", bus.HEAD, 0);
        check("rst_shift_en", bus.SHIFT_EN, 0);
        check("rst_busy", bus.BUSY, 0);
        check("rst_done", bus.DONE, 0);
        check("rst_rdata", bus.RDATA, 0);
        check("rst_rvalid", bus.RVALID, 0);
        RSTN = 1'b1;
        idle_gap(2);

        do_load(8'hA5, 8'h3C, 8'hF0, 0, 0, 0, 1'b0);
        idle_gap(1);
        do_load(8'hA5, 8'h3C, 8'hF0, 0, 0, 0, 1'b0);
        idle_gap(2);
        do_load(8'h5A, 8'hC3, 8'h0F, 0, 5, 0, 1'b0);
        idle_gap(1);
        do_load(8'h12, 8'h34, 8'h56, 0, 0, 0, 1'b1);
        idle_gap(1);

        for (int i = 0; i < 12; i++) begin
            do_load(8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1'($urandom));
            idle_gap(int'($urandom_range(1, 3)));
        end

        reset_mid();
        idle_gap(1);
        do_load(8'($urandom), 8'($urandom), 8'($urandom), 1, 0, 2, 1'b1);
        idle_gap(1);

        len1_load();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Parallel-to-serial loader that drives the head of a configuration-flip-flop (CCFF) chain of `DFF`/`DFFSRQ` cells. It accepts bitstream words over a valid/ready interface and shifts exactly `CHAIN_LEN` bits, MSB-first, into the chain. It sits between the bitstream source (JTAG/SPI bridge or testbench) and the fabric's configuration chain. An optional readback path captures the bits that emerge at the chain tail.

## Interface
Parameters:
- `CHAIN_LEN`, default 64: total chain bits to shift, must be ≥ 1.
- `WORD_W`, default 8: input word width, must be ≥ 1.

Ports:
- `CK`  in  1  single clock, rising edge.
- `RSTN`  in  1  asynchronous, active-low reset.
- `START`  in  1  one-cycle request to begin a load; sampled only in IDLE.
- `WDATA`  in  `WORD_W`  bitstream word; bit `WORD_W-1` is shifted first.
- `WVALID`  in  1  `WDATA` valid.
- `WREADY`  out  1  loader can accept a word.
- `HEAD`  out  1  serial data to the chain head `D`.
- `SHIFT_EN`  out  1  chain clock enable; the chain captures `HEAD` on a `CK` edge where `SHIFT_EN`=1.
- `TAIL`  in  1  chain tail `Q`; used only with readback.
- `BUSY`  out  1  high in LOAD and SHIFT.
- `DONE`  out  1  one-cycle pulse after the final bit.
- `RDATA`  out  `WORD_W`  captured readback word.
- `RVALID`  out  1  one-cycle pulse, `RDATA` valid.

## Operation
- The FSM has four states: IDLE, LOAD, SHIFT and DONE.
- **IDLE**
  - `START`=1 → LOAD, and the bit counter clears to 0.
  - All other inputs are ignored.
- **LOAD**
  - `WREADY`=1.
  - `WVALID`&&`WREADY` at an edge latches `WDATA` into the shift register.
  - It also sets `k` = min(`WORD_W`, `CHAIN_LEN` − bits_sent) → SHIFT.
- **SHIFT**
  - Lasts `k` cycles, with `SHIFT_EN`=1 and `HEAD` = current shift-register MSB.
  - The register shifts left by one each cycle, and bits_sent increments on each shift edge.
  - After the k-th shift edge: bits_sent == `CHAIN_LEN` → DONE, else → LOAD.
- **DONE**
  - `DONE`=1 for one cycle, then → IDLE.
- **Partial last word**: only the top `k` bits are shifted and the low `WORD_W`−`k` bits are discarded.
- **Bit order**: the first bit shifted ends at the chain cell farthest from the head, i.e. bit `CHAIN_LEN`-1 of the chain.
- **`START` while not IDLE**: ignored, with no restart.
- **`WVALID` outside LOAD**: ignored; the word is held by the source.
- **Counter width**: $clog2(`CHAIN_LEN`+1). There is no wrap-around; the counter never exceeds `CHAIN_LEN`.
- **Reset**
  - `RSTN` low at any time, including mid-shift, forces IDLE immediately.
  - Reset values: `WREADY`=0, `HEAD`=0, `SHIFT_EN`=0, `BUSY`=0, `DONE`=0, `RDATA`=0, `RVALID`=0, counter 0.
  - Chain contents are then undefined and a new `START` is required.

## Timing
- All outputs are registered and change only after a `CK` edge (or on async reset).
- `START` sampled at edge e → `WREADY`=1 and `BUSY`=1 from cycle e+1.
- Word accepted at edge t → `SHIFT_EN`=1 in cycles t+1 … t+k, and `WREADY`=0 during SHIFT.
- There is a minimum one-cycle LOAD gap between words, so a full word costs `WORD_W`+1 cycles.
- `DONE` is high in the cycle after the last `SHIFT_EN` cycle, and `BUSY` is low in that same cycle.
- With words always available: total = 1 + ⌈`CHAIN_LEN`/`WORD_W`⌉ + `CHAIN_LEN` cycles from `START` to `DONE`.

## Configuration
- Macro: `CCFF_READBACK_EN`.
- **Defined**
  - `TAIL` is sampled on every edge where `SHIFT_EN`=1, before the chain shifts, into a left-shifting capture register.
  - After the last shift of each word, `RDATA` is loaded and `RVALID` pulses in the following cycle, the same cycle as LOAD or `DONE`.
  - For a partial word, captured bits occupy `RDATA[k-1:0]`, first-captured bit at `[k-1]`, upper bits 0.
  - `RDATA` holds its value until the next capture.
- **Undefined**
  - `RDATA`=0 and `RVALID`=0 constantly; `TAIL` is unused.
  - The capture register is not built.

## Test plan
- **Nominal load**, `CHAIN_LEN`=20, `WORD_W`=8, words 0xA5, 0x3C, 0xF0 always valid, `START` at edge 0 → `HEAD` sequence 10100101 00111100 1111, 20 `SHIFT_EN` cycles, `DONE` at cycle 24, `BUSY` low at cycle 24.
- **Source stall**: `WVALID` dropped for 5 cycles before word 2 → LOAD holds `WREADY`=1, no `SHIFT_EN`, and `DONE` is delayed by exactly 5 cycles.
- **`START` while busy**: second `START` pulsed mid-shift → ignored, and bit count and `DONE` timing are unchanged.
- **Reset mid-operation**: `RSTN` low during the 3rd shift of word 1 → all outputs 0 immediately, IDLE. A new `START` then completes a full 20-bit load.
- **Readback** (`CCFF_READBACK_EN`, 20-bit chain model preloaded with 0x5A, 0x0F, 0x3):
  - Loading any stream gives `RDATA`=0x5A, then 0x0F, then 0x03, with `RVALID` pulses at cycles 10, 19 and 24.
  - Reloading 0xA5, 0x3C, 0xF0 returns 0xA5, 0x3C, 0x0F.
- **Edge case** `CHAIN_LEN`=1: one word 0x80 → a single `SHIFT_EN` cycle with `HEAD`=1, then `DONE`.
